// File: rtl/cpu_csr_unit_pkg.sv
// Shared CSR addresses, op codes, FSM states and decode helpers for cpu_csr_unit.
// Latency: none (package only).
// Backpressure: n/a.
package cpu_csr_unit_pkg;

  localparam int XLEN_FIXED = 32;

  // CSR addresses implemented by the downstream register file
  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCYCLE = 12'hB00;

  // Operation codes presented by the execute stage; 9..15 are illegal
  localparam logic [3:0] OP_CSRRW  = 4'd0;
  localparam logic [3:0] OP_CSRRS  = 4'd1;
  localparam logic [3:0] OP_CSRRC  = 4'd2;
  localparam logic [3:0] OP_CSRRWI = 4'd3;
  localparam logic [3:0] OP_CSRRSI = 4'd4;
  localparam logic [3:0] OP_CSRRCI = 4'd5;
  localparam logic [3:0] OP_ECALL  = 4'd6;
  localparam logic [3:0] OP_EBREAK = 4'd7;
  localparam logic [3:0] OP_MRET   = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EXEC      = 3'd1,
    ST_TRAP_SAVE = 3'd2,
    ST_TRAP_JUMP = 3'd3,
    ST_RET       = 3'd4
  } state_e;

  // Request fields captured at acceptance
  typedef struct packed {
    logic [3:0]  op;
    logic [11:0] csr;
    logic [4:0]  src;
    logic [31:0] rs1;
    logic [31:0] pc;
  } req_t;

  function automatic logic csr_supported(input logic [11:0] addr);
    return (addr == CSR_MTVEC) || (addr == CSR_MEPC) || (addr == CSR_MCYCLE);
  endfunction

  function automatic logic is_imm_op(input logic [3:0] op);
    return (op == OP_CSRRWI) || (op == OP_CSRRSI) || (op == OP_CSRRCI);
  endfunction

endpackage

// File: rtl/cpu_csr_unit_if.sv
// Bundles the execute-stage request, CSR-file ports and retirement outputs.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready handshake; all other signals are strobes.
// master = execute stage plus CSR file side; slave = cpu_csr_unit.
interface cpu_csr_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [11:0] req_csr;
  logic [4:0]  req_src;
  logic [31:0] req_rs1;
  logic [31:0] req_pc;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_wenable;
  logic [31:0] rd_wdata;
  logic        rd_wenable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        done;
  logic        exc;

  modport master (
    output req_valid, req_op, req_csr, req_src, req_rs1, req_pc, csr_rdata,
    input  req_ready, csr_raddr, csr_waddr, csr_wdata, csr_wenable,
           rd_wdata, rd_wenable, redirect_valid, redirect_pc, done, exc
  );

  modport slave (
    input  req_valid, req_op, req_csr, req_src, req_rs1, req_pc, csr_rdata,
    output req_ready, csr_raddr, csr_waddr, csr_wdata, csr_wenable,
           rd_wdata, rd_wenable, redirect_valid, redirect_pc, done, exc
  );
endinterface

// File: rtl/cpu_csr_alu.sv
// Computes the new CSR value and write enable for Zicsr read-modify-write ops.
// Latency: combinational.
// Backpressure: none.
// Ports: op, old (current CSR value), operand, src_zero -> new_val, wen, illegal.
module cpu_csr_alu
  import cpu_csr_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] old,
  input  logic [31:0] operand,
  input  logic        src_zero,
  output logic [31:0] new_val,
  output logic        wen,
  output logic        illegal
);

  // illegal flags anything that is not a CSR read-modify-write op; the caller
  // separates MRET/ECALL/EBREAK from truly undefined codes.
  always_comb begin
    new_val = old;
    wen     = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_CSRRW, OP_CSRRWI: begin
        new_val = operand;
        wen     = 1'b1;
      end
      OP_CSRRS, OP_CSRRSI: begin
        new_val = old | operand;
        wen     = !src_zero;
      end
      OP_CSRRC, OP_CSRRCI: begin
        new_val = old & ~operand;
        wen     = !src_zero;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_csr_unit.sv
// Executes CSR ops, ECALL/EBREAK/illegal traps and MRET against an external CSR file.
// Latency: CSR op and MRET retire 1 cycle after accept; traps write mepc at +1, redirect/done at +2.
// Backpressure: req_ready only in IDLE and only out of reset; one request in flight.
// Ports: clk, rst_n (sync, active-low), bus (cpu_csr_unit_if.slave: request, CSR file, rd, redirect, done/exc).
module cpu_csr_unit
  import cpu_csr_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_csr_unit_if.slave  bus
);

  state_e            state, state_nxt;
  req_t              lat;
  logic              accept;
  logic [3:0]        alu_op;
  logic [XLEN-1:0]   operand;
  logic [31:0]       alu_new;
  logic              alu_wen;
  logic              alu_illegal;

  assign accept = bus.req_valid && bus.req_ready;

  // In IDLE the ALU only serves decode of the incoming op; afterwards it
  // works on the latched request.
  assign alu_op  = (state == ST_IDLE) ? bus.req_op : lat.op;
  assign operand = is_imm_op(lat.op) ? {27'b0, lat.src} : lat.rs1;

  cpu_csr_alu u_alu (
    .op       (alu_op),
    .old      (bus.csr_rdata),
    .operand  (operand),
    .src_zero (lat.src == 5'd0),
    .new_val  (alu_new),
    .wen      (alu_wen),
    .illegal  (alu_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      lat   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat.op  <= bus.req_op;
        lat.csr <= bus.req_csr;
        lat.src <= bus.req_src;
        lat.rs1 <= bus.req_rs1;
        lat.pc  <= bus.req_pc;
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    bus.req_ready      = 1'b0;
    bus.csr_raddr      = 12'h0;
    bus.csr_waddr      = 12'h0;
    bus.csr_wdata      = 32'h0;
    bus.csr_wenable    = 1'b0;
    bus.rd_wdata       = 32'h0;
    bus.rd_wenable     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.done           = 1'b0;
    bus.exc            = 1'b0;

    case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (!alu_illegal && csr_supported(bus.req_csr)) begin
            state_nxt = ST_EXEC;
          end else if (bus.req_op == OP_MRET) begin
            state_nxt = ST_RET;
          end else begin
            // ECALL, EBREAK, unsupported CSR and undefined op codes all trap
            state_nxt = ST_TRAP_SAVE;
          end
        end
      end
      ST_EXEC: begin
        bus.csr_raddr  = lat.csr;
        bus.rd_wdata   = bus.csr_rdata;
        bus.rd_wenable = 1'b1;
        if (alu_wen) begin
          bus.csr_wenable = 1'b1;
          bus.csr_waddr   = lat.csr;
          bus.csr_wdata   = alu_new;
        end
        bus.done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_TRAP_SAVE: begin
        bus.csr_wenable = 1'b1;
        bus.csr_waddr   = CSR_MEPC;
        bus.csr_wdata   = lat.pc;
        state_nxt       = ST_TRAP_JUMP;
      end
      ST_TRAP_JUMP: begin
        // mtvec read here is the pre-trap value: the mepc write landed last cycle
        bus.csr_raddr      = CSR_MTVEC;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = bus.csr_rdata & ~32'h3;
        bus.done           = 1'b1;
        bus.exc            = 1'b1;
        state_nxt          = ST_IDLE;
      end
      ST_RET: begin
        bus.csr_raddr      = CSR_MEPC;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = bus.csr_rdata & ~32'h3;
        bus.done           = 1'b1;
        state_nxt          = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Reset wins over whatever state is mid-flight: nothing leaves the unit.
    if (!rst_n) begin
      state_nxt          = ST_IDLE;
      bus.req_ready      = 1'b0;
      bus.csr_raddr      = 12'h0;
      bus.csr_waddr      = 12'h0;
      bus.csr_wdata      = 32'h0;
      bus.csr_wenable    = 1'b0;
      bus.rd_wdata       = 32'h0;
      bus.rd_wenable     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.done           = 1'b0;
      bus.exc            = 1'b0;
    end
  end

endmodule
